// File: rtl/cordic_iter_seq.sv
// Sequencer for the 16-bit CORDIC iteration datapath: owns the residual-angle
// register and the angle ROM, and schedules the hyperbolic repeat passes.
module cordic_iter_seq #(
  parameter int ITERS = 16,
  parameter int ZW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [ZW-1:0] z_in,
  output logic          ld,
  output logic          en,
  output logic [3:0]    iter_idx,
  output logic          rep,
  output logic          dir,
  output logic [ZW-1:0] z_out,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'(ITERS - 1);

  // Angle ROM in Q2.13: round(atan(2^-i)*8192) or round(atanh(2^-i)*8192).
  function automatic logic [15:0] atab(input logic hyp, input logic [3:0] i);
    logic [15:0] v;
    v = 16'd0;
    if (hyp) begin
      case (i)
        4'd0:    v = 16'd0;
        4'd1:    v = 16'd4500;
        4'd2:    v = 16'd2092;
        4'd3:    v = 16'd1029;
        4'd4:    v = 16'd513;
        4'd5:    v = 16'd256;
        4'd6:    v = 16'd128;
        4'd7:    v = 16'd64;
        4'd8:    v = 16'd32;
        4'd9:    v = 16'd16;
        4'd10:   v = 16'd8;
        4'd11:   v = 16'd4;
        4'd12:   v = 16'd2;
        4'd13:   v = 16'd1;
        4'd14:   v = 16'd1;
        4'd15:   v = 16'd0;
        default: v = 16'd0;
      endcase
    end else begin
      case (i)
        4'd0:    v = 16'd6434;
        4'd1:    v = 16'd3798;
        4'd2:    v = 16'd2007;
        4'd3:    v = 16'd1019;
        4'd4:    v = 16'd511;
        4'd5:    v = 16'd256;
        4'd6:    v = 16'd128;
        4'd7:    v = 16'd64;
        4'd8:    v = 16'd32;
        4'd9:    v = 16'd16;
        4'd10:   v = 16'd8;
        4'd11:   v = 16'd4;
        4'd12:   v = 16'd2;
        4'd13:   v = 16'd1;
        4'd14:   v = 16'd0;
        4'd15:   v = 16'd0;
        default: v = 16'd0;
      endcase
    end
    return v;
  endfunction

  logic [1:0]    state_r, state_s;
  logic          mode_r, mode_s;
  logic [3:0]    cnt_r, cnt_s;
  logic          rep_r, rep_s;
  logic [ZW-1:0] z_r, z_s;
  logic          ld_r, ld_s;
  logic          en_r, en_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          dir_s;
  logic          rep_point_s;
  logic [ZW-1:0] ang_s;

  assign dir_s = ~z_r[ZW-1];
  assign ang_s = ZW'(atab(mode_r, cnt_r));
  // Shift 13 only gets a second pass when the table actually reaches it.
  assign rep_point_s = mode_r && ((cnt_r == 4'd4) || ((ITERS > 13) && (cnt_r == 4'd13)));

  // Next-state, counter, residual-angle and registered-output decode.
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    cnt_s   = cnt_r;
    rep_s   = rep_r;
    z_s     = z_r;
    ld_s    = 1'b0;
    en_s    = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_LOAD;
          mode_s  = mode;
          z_s     = z_in;
          ld_s    = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_ITER;
        cnt_s   = mode_r ? 4'd1 : 4'd0;
        rep_s   = 1'b0;
        en_s    = 1'b1;
        busy_s  = 1'b1;
      end
      ST_ITER: begin
        if (dir_s) begin
          z_s = z_r - ang_s;
        end else begin
          z_s = z_r + ang_s;
        end
        if (rep_point_s && !rep_r) begin
          rep_s  = 1'b1;
          en_s   = 1'b1;
          busy_s = 1'b1;
        end else if (cnt_r == LAST_IDX) begin
          state_s = ST_DONE;
          rep_s   = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s  = cnt_r + 4'd1;
          rep_s  = 1'b0;
          en_s   = 1'b1;
          busy_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        rep_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= 1'b0;
      cnt_r   <= 4'd0;
      rep_r   <= 1'b0;
      z_r     <= '0;
      ld_r    <= 1'b0;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      cnt_r   <= cnt_s;
      rep_r   <= rep_s;
      z_r     <= z_s;
      ld_r    <= ld_s;
      en_r    <= en_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign ld       = ld_r;
  assign en       = en_r;
  assign iter_idx = cnt_r;
  assign rep      = rep_r;
  assign dir      = en_r & dir_s;
  assign z_out    = z_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_cordic_iter_seq.sv
// Randomized bench for cordic_iter_seq against a schedule/angle model built
// from real-valued atan/atanh tables.
module tb_cordic_iter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] z_in;
  logic        ld, en, rep, dir, busy, done;
  logic [3:0]  iter_idx;
  logic [15:0] z_out;

  int total = 0;
  int fails = 0;
  int ctab[16];
  int htab[16];

  cordic_iter_seq #(.ITERS(16), .ZW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .z_in(z_in),
    .ld(ld), .en(en), .iter_idx(iter_idx), .rep(rep), .dir(dir),
    .z_out(z_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; noise=1 sprinkles start pulses that must be ignored.
  task automatic run(input logic m, input logic signed [15:0] z0, input bit noise);
    int              sidx[$];
    bit              srep[$];
    logic signed [15:0] z;
    int              a;
    for (int i = (m ? 1 : 0); i < 16; i++) begin
      sidx.push_back(i);
      srep.push_back(1'b0);
      if (m && (i == 4 || i == 13)) begin
        sidx.push_back(i);
        srep.push_back(1'b1);
      end
    end
    start = 1'b1; mode = m; z_in = z0;
    tick();
    start = 1'b0;
    chk("load_ld", ld, 1);
    chk("load_busy", busy, 1);
    chk("load_en", en, 0);
    chk("load_z", $signed(z_out), z0);
    if (noise) begin
      mode = ~m;
      z_in = 16'($urandom);
    end
    z = z0;
    for (int k = 0; k < sidx.size(); k++) begin
      tick();
      chk("iter_en", en, 1);
      chk("iter_busy", busy, 1);
      chk("iter_ld", ld, 0);
      chk("iter_done", done, 0);
      chk("iter_idx", iter_idx, sidx[k]);
      chk("iter_rep", rep, srep[k]);
      chk("iter_dir", dir, (z >= 0) ? 1 : 0);
      chk("iter_z", $signed(z_out), z);
      a = m ? htab[sidx[k]] : ctab[sidx[k]];
      z = (z >= 0) ? z - 16'(a) : z + 16'(a);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        z_in  = 16'($urandom);
        mode  = 1'($urandom_range(0, 1));
      end
    end
    tick();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_en", en, 0);
    chk("done_ld", ld, 0);
    chk("done_z", $signed(z_out), z);
    start = noise ? 1'b1 : 1'b0;
    if (noise) z_in = 16'($urandom);
    tick();
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_en", en, 0);
    chk("idle_ld", ld, 0);
    chk("idle_z", $signed(z_out), z);
  endtask

  initial begin
    bit saw_done;
    for (int i = 0; i < 16; i++) begin
      ctab[i] = int'($floor($atan(2.0 ** (-i)) * 8192.0 + 0.5));
      htab[i] = (i == 0) ? 0 : int'($floor($atanh(2.0 ** (-i)) * 8192.0 + 0.5));
    end
    rst = 1'b1; start = 1'b0; mode = 1'b0; z_in = 16'd0;
    tick();
    tick();
    chk("rst_ld", ld, 0);
    chk("rst_en", en, 0);
    chk("rst_rep", rep, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", iter_idx, 0);
    chk("rst_z", $signed(z_out), 0);
    rst = 1'b0;
    tick();

    run(1'b0, 16'sd0, 1'b0);
    run(1'b1, 16'sd4096, 1'b0);
    run(1'b0, -16'sd32768, 1'b0);
    run(1'b1, 16'sd4096, 1'b1);

    // Reset during the 5th iteration cycle.
    start = 1'b1; mode = 1'b0; z_in = 16'sd1234;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_en", en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ld", ld, 0);
    chk("mrst_en", en, 0);
    chk("mrst_rep", rep, 0);
    chk("mrst_dir", dir, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_idx", iter_idx, 0);
    chk("mrst_z", $signed(z_out), 0);
    saw_done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("mrst_quiet", saw_done, 0);
    run(1'b0, 16'sd1234, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
